// File: rtl/m_pipe_pkg.sv
// m_pipe shared definitions: widths, ctrl bit layout, occupancy encoding.
// Optional perf counters are enabled with M_PIPE_PERF_EN.
package m_pipe_pkg;

  localparam int XLEN_D = 32;
  localparam int RW_D   = 5;

  localparam int CTRL_LOAD   = 7;
  localparam int CTRL_STORE  = 6;
  localparam int CTRL_F3_HI  = 5;
  localparam int CTRL_F3_LO  = 3;
  localparam int CTRL_SYS    = 2;
  localparam int CTRL_JUMP   = 1;
  localparam int CTRL_BRANCH = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // pc, res, npc, src2, cnd, rd_wen, rd, ctrl
  function automatic int beat_w(input int xlen, input int rw);
    return 4 * xlen + 2 + rw + 8;
  endfunction

endpackage

// File: rtl/m_pipe_reg.sv
// m_pipe payload register: load enable, selects fresh input or skid copy.
// Used for both the main and the skid slot of the E->M buffer.
module m_pipe_reg #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_sel_skid,
  input  logic [W-1:0] i_d,
  input  logic [W-1:0] i_skid,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_sel_skid ? i_skid : i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/m_pipe.sv
// m_pipe: E->M boundary, two-entry skid buffer with registered ready.
// Define M_PIPE_PERF_EN to add stall / full-cycle perf counters.
module m_pipe
  import m_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int RW   = RW_D
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            e_valid_i,
  output logic            e_ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] res_i,
  input  logic [XLEN-1:0] npc_i,
  input  logic            cnd_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic [RW-1:0]   rd_i,
  input  logic            rd_wen_i,
  input  logic [7:0]      ctrl_i,
  output logic            m_valid_o,
  input  logic            M_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] res_o,
  output logic [XLEN-1:0] npc_o,
  output logic [XLEN-1:0] src2_o,
  output logic            cnd_o,
  output logic            rd_wen_o,
  output logic [RW-1:0]   rd_o,
  output logic [7:0]      ctrl_o
`ifdef M_PIPE_PERF_EN
  ,
  output logic [31:0]     perf_stall_o,
  output logic [31:0]     perf_full_o
`endif
);

  localparam int BW = beat_w(XLEN, RW);

  state_t         r_state;
  state_t         w_nstate;
  logic           w_in_fire;
  logic           w_out_fire;
  logic           w_main_ld;
  logic           w_main_sel;
  logic           w_skid_ld;
  logic [BW-1:0]  w_in;
  logic [BW-1:0]  w_main_q;
  logic [BW-1:0]  w_skid_q;

  assign w_in_fire  = e_valid_i & e_ready_o;
  assign w_out_fire = m_valid_o & M_ready_i;

  assign w_in = {pc_i, res_i, npc_i, src2_i,
                 cnd_i, rd_wen_i, rd_i, ctrl_i};

  // Flush suppresses every payload write; the dropped beat still handshakes.
  always_comb begin
    w_nstate   = r_state;
    w_main_ld  = 1'b0;
    w_main_sel = 1'b0;
    w_skid_ld  = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_nstate  = ONE;
          w_main_ld = 1'b1;
        end
      end
      ONE: begin
        if (w_in_fire & w_out_fire) begin
          w_main_ld = 1'b1;
        end else if (w_in_fire) begin
          w_nstate  = FULL;
          w_skid_ld = 1'b1;
        end else if (w_out_fire) begin
          w_nstate  = EMPTY;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_nstate   = ONE;
          w_main_ld  = 1'b1;
          w_main_sel = 1'b1;
        end
      end
      default: w_nstate = EMPTY;
    endcase
    if (flush_i) begin
      w_nstate  = EMPTY;
      w_main_ld = 1'b0;
      w_skid_ld = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= EMPTY;
      e_ready_o <= 1'b1;
      m_valid_o <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      e_ready_o <= (w_nstate != FULL);
      m_valid_o <= (w_nstate != EMPTY);
    end
  end

  m_pipe_reg #(.W(BW)) u_main (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_main_ld),
    .i_sel_skid (w_main_sel),
    .i_d        (w_in),
    .i_skid     (w_skid_q),
    .o_q        (w_main_q)
  );

  m_pipe_reg #(.W(BW)) u_skid (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_skid_ld),
    .i_sel_skid (1'b0),
    .i_d        (w_in),
    .i_skid     ({BW{1'b0}}),
    .o_q        (w_skid_q)
  );

  assign {pc_o, res_o, npc_o, src2_o,
          cnd_o, rd_wen_o, rd_o, ctrl_o} = w_main_q;

`ifdef M_PIPE_PERF_EN
  logic [31:0] r_stall;
  logic [31:0] r_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
      r_full  <= '0;
    end else begin
      if (m_valid_o & ~M_ready_i) r_stall <= r_stall + 32'd1;
      if (r_state == FULL)        r_full  <= r_full + 32'd1;
    end
  end

  assign perf_stall_o = r_stall;
  assign perf_full_o  = r_full;
`endif

endmodule

// File: tb/tb_m_pipe.sv
// m_pipe bench: queue-based reference model plus directed literal checks.
// Perf counter checks are active when M_PIPE_PERF_EN is defined.
module tb_m_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush_i = 1'b0;
  logic        e_valid_i = 1'b0;
  logic        e_ready_o;
  logic [31:0] pc_i = '0;
  logic [31:0] res_i = '0;
  logic [31:0] npc_i = '0;
  logic        cnd_i = 1'b0;
  logic [31:0] src2_i = '0;
  logic [4:0]  rd_i = '0;
  logic        rd_wen_i = 1'b0;
  logic [7:0]  ctrl_i = '0;
  logic        m_valid_o;
  logic        M_ready_i = 1'b0;
  logic [31:0] pc_o, res_o, npc_o, src2_o;
  logic        cnd_o, rd_wen_o;
  logic [4:0]  rd_o;
  logic [7:0]  ctrl_o;
`ifdef M_PIPE_PERF_EN
  logic [31:0] perf_stall_o, perf_full_o;
  logic [31:0] st_m = '0;
  logic [31:0] fu_m = '0;
  logic [31:0] s0, f0;
`endif

  always #5 clock = ~clock;

  m_pipe dut (
    .clock     (clock),
    .reset     (reset),
    .flush_i   (flush_i),
    .e_valid_i (e_valid_i),
    .e_ready_o (e_ready_o),
    .pc_i      (pc_i),
    .res_i     (res_i),
    .npc_i     (npc_i),
    .cnd_i     (cnd_i),
    .src2_i    (src2_i),
    .rd_i      (rd_i),
    .rd_wen_i  (rd_wen_i),
    .ctrl_i    (ctrl_i),
    .m_valid_o (m_valid_o),
    .M_ready_i (M_ready_i),
    .pc_o      (pc_o),
    .res_o     (res_o),
    .npc_o     (npc_o),
    .src2_o    (src2_o),
    .cnd_o     (cnd_o),
    .rd_wen_o  (rd_wen_o),
    .rd_o      (rd_o),
    .ctrl_o    (ctrl_o)
`ifdef M_PIPE_PERF_EN
    ,
    .perf_stall_o (perf_stall_o),
    .perf_full_o  (perf_full_o)
`endif
  );

  typedef struct {
    logic [31:0] pc, res, npc, src2;
    logic        cnd, rd_wen;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } beat_t;

  beat_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: at most two beats in flight, FIFO order, flush empties it.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
`ifdef M_PIPE_PERF_EN
      st_m = '0;
      fu_m = '0;
`endif
    end else begin
      beat_t b;
      bit mv, er;
      mv = q.size() > 0;
      er = q.size() < 2;
`ifdef M_PIPE_PERF_EN
      if (mv && !M_ready_i) st_m = st_m + 1;
      if (q.size() == 2)    fu_m = fu_m + 1;
`endif
      if (mv && M_ready_i) void'(q.pop_front());
      if (e_valid_i && er) begin
        b.pc = pc_i; b.res = res_i; b.npc = npc_i; b.src2 = src2_i;
        b.cnd = cnd_i; b.rd_wen = rd_wen_i; b.rd = rd_i; b.ctrl = ctrl_i;
        q.push_back(b);
      end
      if (flush_i) q.delete();
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("m_valid", {31'b0, m_valid_o}, {31'b0, q.size() > 0});
      chk("e_ready", {31'b0, e_ready_o}, {31'b0, q.size() < 2});
      if (q.size() > 0) begin
        chk("pc",     pc_o,   q[0].pc);
        chk("res",    res_o,  q[0].res);
        chk("npc",    npc_o,  q[0].npc);
        chk("src2",   src2_o, q[0].src2);
        chk("cnd",    {31'b0, cnd_o},    {31'b0, q[0].cnd});
        chk("rd_wen", {31'b0, rd_wen_o}, {31'b0, q[0].rd_wen});
        chk("rd",     {27'b0, rd_o},     {27'b0, q[0].rd});
        chk("ctrl",   {24'b0, ctrl_o},   {24'b0, q[0].ctrl});
      end
`ifdef M_PIPE_PERF_EN
      chk("perf_stall", perf_stall_o, st_m);
      chk("perf_full",  perf_full_o,  fu_m);
`endif
    end
  end

  task automatic cyc(input logic v, input logic [31:0] r,
                     input logic mr, input logic fl);
    @(negedge clock);
    #1;
    e_valid_i = v;
    res_i     = r;
    npc_i     = r ^ 32'h1000;
    cnd_i     = ~r[0];
    M_ready_i = mr;
    flush_i   = fl;
    pc_i      = $urandom;
    src2_i    = $urandom;
    rd_i      = 5'($urandom);
    rd_wen_i  = 1'($urandom);
    ctrl_i    = 8'($urandom);
  endtask

  initial begin
    #12;
    chk("rst_valid", {31'b0, m_valid_o}, 32'd0);
    chk("rst_ready", {31'b0, e_ready_o}, 32'd1);
    chk("rst_res",   res_o,  32'd0);
    chk("rst_ctrl",  {24'b0, ctrl_o}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // streaming
    cyc(1, 32'h1, 1, 0);
    cyc(1, 32'h2, 1, 0);
    chk("str1", res_o, 32'h1);
    chk("str_rdy1", {31'b0, e_ready_o}, 32'd1);
    cyc(1, 32'h3, 1, 0);
    chk("str2", res_o, 32'h2);
    chk("str_rdy2", {31'b0, e_ready_o}, 32'd1);
    cyc(0, 32'h0, 1, 0);
    chk("str3", res_o, 32'h3);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);
    chk("idle", {31'b0, m_valid_o}, 32'd0);

    // backpressure
    cyc(1, 32'hA, 0, 0);
    cyc(1, 32'hB, 0, 0);
    chk("bp_a", res_o, 32'hA);
    cyc(0, 32'h0, 0, 0);
    chk("bp_full", {31'b0, e_ready_o}, 32'd0);
    chk("bp_hold", res_o, 32'hA);
    cyc(0, 32'h0, 1, 0);
    chk("bp_a2", res_o, 32'hA);
    cyc(0, 32'h0, 1, 0);
    chk("bp_b", res_o, 32'hB);
    cyc(0, 32'h0, 1, 0);
    chk("bp_end", {31'b0, m_valid_o}, 32'd0);

    // simultaneous in/out in ONE
    cyc(1, 32'h5, 0, 0);
    cyc(1, 32'h6, 1, 0);
    chk("sim5", res_o, 32'h5);
    cyc(0, 32'h0, 0, 0);
    chk("sim6", res_o, 32'h6);
    chk("sim_npc", npc_o, 32'h1006);
    chk("sim_cnd", {31'b0, cnd_o}, 32'd1);
    chk("sim_rdy", {31'b0, e_ready_o}, 32'd1);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);

    // flush in FULL
    cyc(1, 32'h7, 0, 0);
    cyc(1, 32'h8, 0, 0);
    cyc(0, 32'h0, 0, 0);
    chk("fl_full", {31'b0, e_ready_o}, 32'd0);
    cyc(1, 32'hC, 0, 1);
    cyc(0, 32'h0, 0, 0);
    chk("fl_valid", {31'b0, m_valid_o}, 32'd0);
    chk("fl_ready", {31'b0, e_ready_o}, 32'd1);
    cyc(0, 32'h0, 1, 0);
    chk("fl_valid2", {31'b0, m_valid_o}, 32'd0);

`ifdef M_PIPE_PERF_EN
    s0 = perf_stall_o;
    f0 = perf_full_o;
    cyc(1, 32'h20, 0, 0);
    cyc(0, 32'h0, 0, 0);
    cyc(0, 32'h0, 0, 0);
    cyc(1, 32'h21, 0, 0);
    cyc(0, 32'h0, 0, 0);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);
    chk("perf_stall4", perf_stall_o - s0, 32'd4);
    chk("perf_full2",  perf_full_o - f0,  32'd2);
`endif

    // reset while FULL
    cyc(1, 32'h30, 0, 0);
    cyc(1, 32'h31, 0, 0);
    cyc(0, 32'h0, 0, 0);
    chk("pre_rst_full", {31'b0, e_ready_o}, 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_valid", {31'b0, m_valid_o}, 32'd0);
    chk("mrst_ready", {31'b0, e_ready_o}, 32'd1);
    chk("mrst_res",   res_o, 32'd0);
    e_valid_i = 1'b0;
    @(negedge clock);
    #1;
    reset = 1'b0;
    cyc(1, 32'h11, 0, 0);
    cyc(0, 32'h0, 0, 0);
    chk("post_rst", res_o, 32'h11);
    chk("post_rst_v", {31'b0, m_valid_o}, 32'd1);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom), $urandom, 1'($urandom),
          $urandom_range(0, 15) == 0);
    end
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m_pipe.md
Name: m_pipe

Overview:
- E→M pipeline boundary register; receiving end of the execute-stage valid/ready handshake.
- Captures execute results (res, npc, cnd) plus the carried control payload when the execute stage presents a valid beat.
- Presents the captured beat to the memory stage.
- Two-entry skid buffer: e_ready_o is a registered function of occupancy, so there is no combinational path from M_ready_i back to e_ready_o; full throughput is sustained.

Parameters:
- XLEN, 32, width of res, pc, npc, store data.
- RW, 5, register index width.

Ports:
- clock  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush_i  in  1  kill all buffered beats and any incoming beat this cycle
- e_valid_i  in  1  execute beat valid
- e_ready_o  out  1  buffer can accept a beat
- pc_i  in  XLEN  instruction pc
- res_i  in  XLEN  ALU result / effective address
- npc_i  in  XLEN  next pc from branch unit
- cnd_i  in  1  branch condition
- src2_i  in  XLEN  store data
- rd_i  in  RW  destination register
- rd_wen_i  in  1  writeback enable
- ctrl_i  in  8  {is_load, is_store, funct3[2:0], is_sys, is_jump, is_branch}
- m_valid_o  out  1  beat valid to memory stage
- M_ready_i  in  1  memory stage accepts
- pc_o, res_o, npc_o, src2_o  out  XLEN  registered payload
- cnd_o, rd_wen_o  out  1  registered payload
- rd_o  out  RW  registered payload
- ctrl_o  out  8  registered payload

Behaviour:
- Reset is asynchronous and active-high.
- Handshakes: in_fire = e_valid_i & e_ready_o; out_fire = m_valid_o & M_ready_i.
- Occupancy state: EMPTY, ONE, FULL; two payload registers, main and skid. Outputs always drive main.
- Reset values: state EMPTY, m_valid_o 0, e_ready_o 1, all payload outputs 0.
- e_ready_o = (state != FULL). m_valid_o = (state != EMPTY).
- Transitions, without flush:
  - EMPTY, in_fire → ONE; main ← input.
  - ONE, in_fire & !out_fire → FULL; skid ← input.
  - ONE, !in_fire & out_fire → EMPTY.
  - ONE, in_fire & out_fire → ONE; main ← input.
  - FULL, out_fire → ONE; main ← skid. in_fire cannot occur in FULL.
  - No fire → hold state and both payloads.
- Latency: input beat appears on outputs 1 cycle after in_fire when main is empty or draining. Otherwise it appears after the older beat leaves.
- Ordering: strict FIFO; beats are never reordered or duplicated.
- Flush:
  - flush_i=1 → next state EMPTY.
  - An in_fire in the same cycle is discarded, but the handshake still completes from the producer's view.
  - An out_fire in the same cycle is honoured downstream.
  - Payload registers are not cleared.
- Payload registers are not cleared on out_fire. Downstream qualifies with m_valid_o.
- Reset mid-operation: immediate return to reset values; in-flight beats are lost.
- X-safety: payload registers are written only on the listed transitions.

Optional Feature:
- M_PIPE_PERF_EN defined:
  - Adds perf_stall_o (out, 32): counts cycles with m_valid_o & !M_ready_i.
  - Adds perf_full_o (out, 32): counts cycles in FULL.
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters absent; the remaining behaviour is identical.

Decomposition:
- Shared package/header holds: XLEN and RW defaults; the ctrl bit-index constants (load=7, store=6, funct3=5:3, sys=2, jump=1, branch=0); state encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- One natural sub-module: m_pipe_reg, a payload register with load enable and select between input and skid. It is instantiated for main and skid.
- Control FSM stays in m_pipe.

Test Plan:
- Reset asserted mid-run with state FULL → same cycle: m_valid_o=0, e_ready_o=1, res_o=0. After release, the first beat res_i=0x11 appears one cycle after in_fire.
- Streaming, M_ready_i=1, beats res 0x1,0x2,0x3 on consecutive cycles → res_o 0x1,0x2,0x3 on the next three cycles. e_ready_o stays 1.
- Backpressure: M_ready_i=0, beats 0xA then 0xB → state FULL, e_ready_o=0, res_o=0xA held. After M_ready_i=1 → 0xA, then 0xB, in order.
- Flush in FULL, with an in-flight beat 0xC offered in the same cycle as flush → next cycle m_valid_o=0, e_ready_o=1; 0xC is never presented.
- Simultaneous in_fire/out_fire in ONE (main 0x5, incoming 0x6) → next cycle state ONE, res_o=0x6, npc_o and cnd_o taken from the 0x6 beat.
- M_PIPE_PERF_EN: 4 stall cycles with 2 in FULL → perf_stall_o=4, perf_full_o=2.
